// File: rtl/snow64_bfloat16_arith_if.sv
// Command/result bundle between the FPU front end and a BFloat16 arithmetic unit.
// The front end drives start/a/b; the unit returns a one-cycle data_valid pulse with data.
interface snow64_bfloat16_arith_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        data_valid;
    logic        can_accept_cmd;
    logic [15:0] data;

    modport master (output start, a, b, input data_valid, can_accept_cmd, data);
    modport slave  (input start, a, b, output data_valid, can_accept_cmd, data);
endinterface

// File: rtl/snow64_bfloat16_arith.sv
// Multi-cycle BFloat16 add / multiply / divide with truncating rounding and flush-to-zero.
// OP selects the datapath at elaboration: 1 = MUL, 2 = DIV, anything else = ADD.
module snow64_bfloat16_arith #(
    parameter logic [1:0] OP = 2'd0
) (
    input logic                    clk,
    input logic                    rst,
    snow64_bfloat16_arith_if.slave bus
);
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [3:0] LAT_M1 = (OP == OP_MUL) ? 4'd2 : (OP == OP_DIV) ? 4'd11 : 4'd3;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic is_zero(input logic [7:0] e);
        return e == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [7:0] e, input logic [6:0] f);
        return (e == 8'hFF) && (f == 7'h00);
    endfunction

    function automatic logic is_nan(input logic [7:0] e, input logic [6:0] f);
        return (e == 8'hFF) && (f != 7'h00);
    endfunction

    function automatic logic [7:0] mant_of(input logic [7:0] e, input logic [6:0] f);
        return (e == 8'h00) ? 8'h00 : {1'b1, f};
    endfunction

    // Saturate the biased exponent to inf / zero and apply the special-case overrides.
    function automatic logic [15:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [6:0] frac,
                                         input logic nan, input logic inf, input logic zero);
        if (nan)                        return 16'h7FC0;
        else if (inf || e > 10'sd254)   return {s, 8'hFF, 7'h00};
        else if (zero || e < 10'sd1)    return {s, 15'h0000};
        else                            return {s, e[7:0], frac};
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, done;
    logic [15:0] a_p0, b_p0;
    logic [15:0] result;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = LAT_M1;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.data_valid <= 1'b0;
            bus.data       <= 16'h0000;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.data_valid <= done;
            if (done) bus.data <= result;
        end
    end

    assign bus.can_accept_cmd = (state == IDLE);

    // Operand capture: held for the whole operation so a/b may change after the start edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= bus.a;
            b_p0 <= bus.b;
        end
    end

    if (OP == OP_MUL) begin : g_mul
        logic [7:0]        ma, mb;
        logic              s_p1, nan_p1, inf_p1, zero_p1;
        logic signed [9:0] e_p1;
        logic [8:0]        prod_p1;
        logic              s_p2, nan_p2, inf_p2, zero_p2;
        logic signed [9:0] e_p2;
        logic [6:0]        frac_p2;

        assign ma = mant_of(a_p0[14:7], a_p0[6:0]);
        assign mb = mant_of(b_p0[14:7], b_p0[6:0]);

        // Stage 1: product (top 9 bits of the 16-bit product), exponent sum, specials
        always_ff @(posedge clk) begin
            s_p1    <= a_p0[15] ^ b_p0[15];
            e_p1    <= $signed({2'b00, a_p0[14:7]}) + $signed({2'b00, b_p0[14:7]}) - 10'sd127;
            prod_p1 <= 9'(({8'h00, ma} * {8'h00, mb}) >> 7);
            nan_p1  <= is_nan(a_p0[14:7], a_p0[6:0]) | is_nan(b_p0[14:7], b_p0[6:0])
                     | (is_zero(a_p0[14:7]) & is_inf(b_p0[14:7], b_p0[6:0]))
                     | (is_inf(a_p0[14:7], a_p0[6:0]) & is_zero(b_p0[14:7]));
            inf_p1  <= is_inf(a_p0[14:7], a_p0[6:0]) | is_inf(b_p0[14:7], b_p0[6:0]);
            zero_p1 <= is_zero(a_p0[14:7]) | is_zero(b_p0[14:7]);
        end

        // Stage 2: normalise by at most one place
        always_ff @(posedge clk) begin
            s_p2    <= s_p1;
            nan_p2  <= nan_p1;
            inf_p2  <= inf_p1;
            zero_p2 <= zero_p1;
            if (prod_p1[8]) begin
                frac_p2 <= prod_p1[7:1];
                e_p2    <= e_p1 + 10'sd1;
            end else begin
                frac_p2 <= prod_p1[6:0];
                e_p2    <= e_p1;
            end
        end

        assign result = pack(s_p2, e_p2, frac_p2, nan_p2, inf_p2, zero_p2);
    end else if (OP == OP_DIV) begin : g_div
        logic [7:0]        ma, mb;
        logic              setup;
        logic [7:0]        rem;
        logic [8:0]        rem_sh;
        logic [10:0]       q;
        logic              s_d, nan_d, inf_d, zero_d;
        logic signed [9:0] e_d;
        logic signed [9:0] e_n;
        logic [6:0]        frac_n;

        assign ma     = mant_of(a_p0[14:7], a_p0[6:0]);
        assign mb     = mant_of(b_p0[14:7], b_p0[6:0]);
        assign setup  = (state == BUSY) && (cnt == LAT_M1);
        assign rem_sh = {rem, 1'b0};

        // Setup resolves the integer quotient bit; each later cycle adds one fraction bit.
        always_ff @(posedge clk) begin
            if (setup) begin
                s_d    <= a_p0[15] ^ b_p0[15];
                e_d    <= $signed({2'b00, a_p0[14:7]}) - $signed({2'b00, b_p0[14:7]}) + 10'sd127;
                nan_d  <= is_nan(a_p0[14:7], a_p0[6:0]) | is_nan(b_p0[14:7], b_p0[6:0])
                        | (is_zero(a_p0[14:7]) & is_zero(b_p0[14:7]))
                        | (is_inf(a_p0[14:7], a_p0[6:0]) & is_inf(b_p0[14:7], b_p0[6:0]));
                inf_d  <= is_inf(a_p0[14:7], a_p0[6:0])
                        | (is_zero(b_p0[14:7]) & ~is_zero(a_p0[14:7]));
                zero_d <= is_zero(a_p0[14:7]) | is_inf(b_p0[14:7], b_p0[6:0]);
                if (ma >= mb) begin
                    q   <= 11'd1;
                    rem <= ma - mb;
                end else begin
                    q   <= 11'd0;
                    rem <= ma;
                end
            end else if (rem_sh >= {1'b0, mb}) begin
                q   <= {q[9:0], 1'b1};
                rem <= 8'(rem_sh - {1'b0, mb});
            end else begin
                q   <= {q[9:0], 1'b0};
                rem <= rem_sh[7:0];
            end
        end

        always_comb begin
            if (q[10]) begin
                frac_n = q[9:3];
                e_n    = e_d;
            end else begin
                frac_n = q[8:2];
                e_n    = e_d - 10'sd1;
            end
        end

        assign result = pack(s_d, e_n, frac_n, nan_d, inf_d, zero_d);
    end else begin : g_add
        logic [7:0]        ma, mb;
        logic              a_big;
        logic [7:0]        e_big, e_small, m_big, m_small, diff;
        logic [3:0]        sh;
        logic [21:0]       wide;
        logic              s_p1, sub_p1, nan_p1, inf_p1;
        logic [7:0]        e_p1;
        logic [11:0]       big_p1, small_p1;
        logic              s_p2, nan_p2, inf_p2;
        logic [7:0]        e_p2;
        logic [12:0]       sum_p2;
        logic [3:0]        lz;
        logic              s_p3, nan_p3, inf_p3, zero_p3;
        logic signed [9:0] e_p3;
        logic [6:0]        frac_p3;

        assign ma = mant_of(a_p0[14:7], a_p0[6:0]);
        assign mb = mant_of(b_p0[14:7], b_p0[6:0]);

        always_comb begin
            a_big   = {a_p0[14:7], ma} >= {b_p0[14:7], mb};
            e_big   = a_big ? a_p0[14:7] : b_p0[14:7];
            e_small = a_big ? b_p0[14:7] : a_p0[14:7];
            m_big   = a_big ? ma : mb;
            m_small = a_big ? mb : ma;
            diff    = e_big - e_small;
            sh      = (diff > 8'd11) ? 4'd11 : diff[3:0];
            wide    = {m_small, 3'b000, 11'h000} >> sh;
        end

        // Stage 1: align smaller operand, 3 guard bits plus sticky
        always_ff @(posedge clk) begin
            s_p1     <= a_big ? a_p0[15] : b_p0[15];
            sub_p1   <= a_p0[15] ^ b_p0[15];
            nan_p1   <= is_nan(a_p0[14:7], a_p0[6:0]) | is_nan(b_p0[14:7], b_p0[6:0])
                      | (is_inf(a_p0[14:7], a_p0[6:0]) & is_inf(b_p0[14:7], b_p0[6:0])
                         & (a_p0[15] ^ b_p0[15]));
            inf_p1   <= is_inf(a_p0[14:7], a_p0[6:0]) | is_inf(b_p0[14:7], b_p0[6:0]);
            e_p1     <= e_big;
            big_p1   <= {m_big, 4'h0};
            small_p1 <= {wide[21:11], |wide[10:0]};
        end

        // Stage 2: magnitude add/subtract (big >= small, so no negative result)
        always_ff @(posedge clk) begin
            s_p2   <= s_p1;
            nan_p2 <= nan_p1;
            inf_p2 <= inf_p1;
            e_p2   <= e_p1;
            sum_p2 <= sub_p1 ? {1'b0, big_p1} - {1'b0, small_p1}
                             : {1'b0, big_p1} + {1'b0, small_p1};
        end

        always_comb begin
            lz = 4'd0;
            for (int i = 0; i < 12; i++) begin
                if (sum_p2[i]) lz = 4'(11 - i);
            end
        end

        // Stage 3: normalise right by one on carry, else left by leading-zero count
        always_ff @(posedge clk) begin
            nan_p3  <= nan_p2;
            inf_p3  <= inf_p2;
            zero_p3 <= (sum_p2 == 13'h0000);
            s_p3    <= s_p2 & (sum_p2 != 13'h0000);
            if (sum_p2[12]) begin
                frac_p3 <= 7'(sum_p2 >> 5);
                e_p3    <= $signed({2'b00, e_p2}) + 10'sd1;
            end else begin
                frac_p3 <= 7'((sum_p2 << lz) >> 4);
                e_p3    <= $signed({2'b00, e_p2}) - $signed({6'h00, lz});
            end
        end

        assign result = pack(s_p3, e_p3, frac_p3, nan_p3, inf_p3, zero_p3);
    end
endmodule

// File: tb/tb_snow64_bfloat16_arith.sv
// Directed bench for the ADD, MUL and DIV variants of snow64_bfloat16_arith.
// Expected values are hand-computed BFloat16 encodings with truncation toward zero.
module tb_snow64_bfloat16_arith;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    snow64_bfloat16_arith_if if_add ();
    snow64_bfloat16_arith_if if_mul ();
    snow64_bfloat16_arith_if if_div ();

    snow64_bfloat16_arith #(.OP(2'd0)) u_add (.clk(clk), .rst(rst), .bus(if_add));
    snow64_bfloat16_arith #(.OP(2'd1)) u_mul (.clk(clk), .rst(rst), .bus(if_mul));
    snow64_bfloat16_arith #(.OP(2'd2)) u_div (.clk(clk), .rst(rst), .bus(if_div));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0:       begin if_add.start = st; if_add.a = a; if_add.b = b; end
            1:       begin if_mul.start = st; if_mul.a = a; if_mul.b = b; end
            default: begin if_div.start = st; if_div.a = a; if_div.b = b; end
        endcase
    endtask

    function automatic logic dv(input int sel);
        case (sel)
            0:       return if_add.data_valid;
            1:       return if_mul.data_valid;
            default: return if_div.data_valid;
        endcase
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return if_add.can_accept_cmd;
            1:       return if_mul.can_accept_cmd;
            default: return if_div.can_accept_cmd;
        endcase
    endfunction

    function automatic logic [15:0] dat(input int sel);
        case (sel)
            0:       return if_add.data;
            1:       return if_mul.data;
            default: return if_div.data;
        endcase
    endfunction

    function automatic int lat_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 3;
            default: return 12;
        endcase
    endfunction

    // Waits (bounded) at falling edges for data_valid; returns cycles since the start edge.
    task automatic wait_valid(input int sel, output int k);
        k = 0;
        while (!dv(sel) && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input string tag);
        int k;
        drive(sel, 1'b1, a, b);
        @(negedge clk);
        drive(sel, 1'b0, ~a, ~b);
        check({tag, "_busy"}, 32'(rdy(sel)), 32'd0);
        wait_valid(sel, k);
        check({tag, "_lat"}, k, lat_of(sel));
        check({tag, "_data"}, dat(sel), exp_d);
        check({tag, "_rdy"}, 32'(rdy(sel)), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(dv(sel)), 32'd0);
    endtask

    initial begin
        int k;
        int pulses;
        drive(0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("rst_valid", 32'(dv(s)), 32'd0);
            check("rst_rdy", 32'(rdy(s)), 32'd1);
            check("rst_data", dat(s), 32'h0000);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 16'h3F80, 16'h4000, 16'h4040, "add_1p2");
        run_op(0, 16'h3F80, 16'hBF80, 16'h0000, "add_cancel");
        run_op(0, 16'h4040, 16'hBF80, 16'h4000, "add_3m1");
        run_op(0, 16'h4000, 16'hBB80, 16'h3FFF, "add_guard");
        run_op(0, 16'h4000, 16'hB7C0, 16'h3FFF, "add_sticky");
        run_op(0, 16'h7FC1, 16'h3F80, 16'h7FC0, "add_nan");
        run_op(0, 16'h7F80, 16'hFF80, 16'h7FC0, "add_infminf");
        run_op(0, 16'h7F80, 16'hBF80, 16'h7F80, "add_inf");

        run_op(1, 16'h3FC0, 16'h4000, 16'h4040, "mul_1p5x2");
        run_op(1, 16'hBFC0, 16'h4000, 16'hC040, "mul_sign");
        run_op(1, 16'h7F00, 16'h4000, 16'h7F80, "mul_ovf");
        run_op(1, 16'h0080, 16'h0080, 16'h0000, "mul_unf");
        run_op(1, 16'h0000, 16'h7F80, 16'h7FC0, "mul_0xinf");
        run_op(1, 16'h7FC1, 16'h3F80, 16'h7FC0, "mul_nan");

        run_op(2, 16'h40C0, 16'h4000, 16'h4040, "div_6d2");
        run_op(2, 16'h3F80, 16'h4040, 16'h3EAA, "div_1d3");
        run_op(2, 16'h3F80, 16'h0000, 16'h7F80, "div_by0");
        run_op(2, 16'h0000, 16'h0000, 16'h7FC0, "div_0d0");
        run_op(2, 16'h7FC1, 16'h3F80, 16'h7FC0, "div_nan");
        run_op(2, 16'hBF80, 16'h4000, 16'hBF00, "div_sign");

        // start pulses while busy must be ignored
        drive(0, 1'b1, 16'h3F80, 16'h4000);
        @(negedge clk);
        drive(0, 1'b1, 16'h4040, 16'h4040);
        k = 0;
        while (!dv(0) && k < 40) begin
            check("hs_busy_rdy", 32'(rdy(0)), 32'd0);
            if (k == 1) drive(0, 1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
            k++;
        end
        check("hs_lat", k, 4);
        check("hs_data", dat(0), 16'h4040);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dv(0)) pulses++;
        end
        check("hs_no_extra", pulses, 0);

        // start coincident with data_valid is accepted
        drive(0, 1'b1, 16'h3F80, 16'h4000);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000);
        wait_valid(0, k);
        check("b2b_first", dat(0), 16'h4040);
        drive(0, 1'b1, 16'h4040, 16'hBF80);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000);
        wait_valid(0, k);
        check("b2b_lat", k, 4);
        check("b2b_data", dat(0), 16'h4000);

        // asynchronous abort two cycles into a divide
        @(negedge clk);
        drive(2, 1'b1, 16'h40C0, 16'h4000);
        @(negedge clk);
        drive(2, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(dv(2)), 32'd0);
        check("abort_rdy", 32'(rdy(2)), 32'd1);
        check("abort_data", dat(2), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dv(2)) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_data_held", dat(2), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 expected completion");
        $fatal(1);
    end
endmodule
